// File: rtl/mul_div_pkg.sv
// Shared types for the multiply/divide unit: op encoding, FSM states, default width.
// Pure declarations, no logic and no latency.
// Nothing here applies backpressure; the package only defines types and helpers.
package mul_div_pkg;

  localparam int MUL_DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PREP = 2'b01,
    ST_CALC = 2'b10,
    ST_FIX  = 2'b11
  } state_e;

  // The high op bit selects divide, and the low bit selects unsigned.
  function automatic logic op_is_div(input op_e o);
    return o[1];
  endfunction

  function automatic logic op_is_signed(input op_e o);
    return ~o[0];
  endfunction

endpackage

// File: rtl/mul_div_step.sv
// One radix-2 iteration on the {upper, lower} accumulator: shift-add or restoring shift-subtract.
// Purely combinational, so the result is available in the same cycle.
// No backpressure; the caller decides when to register acc_next.
module mul_div_step
  import mul_div_pkg::*;
#(
  parameter int WIDTH = MUL_DIV_WIDTH
) (
  input  logic                 mode_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     opnd,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] rem_low;
  logic [WIDTH-1:0] rem_diff;
  logic             div_ge;

  // Multiply adds the multiplicand into the upper half when the multiplier LSB is set, then shifts right.
  // Divide shifts left and subtracts the divisor when the widened partial remainder is large enough.
  // The bit shifted out of the top of the upper half means the remainder is already >= 2^WIDTH.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    rem_low  = {acc[2*WIDTH-2:WIDTH], acc[WIDTH-1]};
    div_ge   = acc[2*WIDTH-1] | (rem_low >= opnd);
    rem_diff = rem_low - opnd;
    if (mode_div) begin
      acc_next = {(div_ge ? rem_diff : rem_low), acc[WIDTH-2:0], div_ge};
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers and MTHI/MTLO writes.
// The result is written WIDTH+2 edges after start. With MUL_DIV_UNIT_FAST_MUL_EN, multiply results are written 2 edges after start.
// start is ignored while busy; direct HI/LO writes are accepted only in IDLE.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = MUL_DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e               state, state_nx;
  op_e                  op_q;
  logic [WIDTH-1:0]     a_q, b_q, opnd;
  logic [2*WIDTH-1:0]   acc, step_nx;
  logic                 neg_q, rneg_q;
  logic [CW-1:0]        cnt;
  logic                 start_fast, fix_wr;
  logic [WIDTH-1:0]     res_hi, res_lo;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  mul_div_step #(.WIDTH(WIDTH)) u_step (
    .mode_div (op_is_div(op_q)),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (step_nx)
  );

`ifdef MUL_DIV_UNIT_FAST_MUL_EN
  logic                      fast_ld;
  logic signed [2*WIDTH-1:0] ext_a, ext_b;
  logic [2*WIDTH-1:0]        fast_prod;

  // The full product comes from sign/zero-extended operands in one cycle; FIX first loads it, then writes it.
  assign ext_a      = {{WIDTH{op_is_signed(op_q) & a_q[WIDTH-1]}}, a_q};
  assign ext_b      = {{WIDTH{op_is_signed(op_q) & b_q[WIDTH-1]}}, b_q};
  assign fast_prod  = ext_a * ext_b;
  assign start_fast = ~op[1];
  assign fix_wr     = op_is_div(op_q) | fast_ld;

  // The flag marks that the single-cycle product is in acc and ready to be written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fast_ld <= 1'b0;
    else        fast_ld <= (state == ST_FIX) && !fix_wr;
  end
`else
  assign start_fast = 1'b0;
  assign fix_wr     = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: IDLE -> PREP -> CALC (WIDTH iterations) -> FIX -> IDLE.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (start) state_nx = start_fast ? ST_FIX : ST_PREP;
      ST_PREP: state_nx = ST_CALC;
      ST_CALC: if (cnt == LAST) state_nx = ST_FIX;
      ST_FIX:  if (fix_wr) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state != ST_IDLE);
  end

  // Sign correction and special cases. A zero divisor bypasses the array result.
  // MIN / -1 needs no special case: the magnitude quotient 2^(WIDTH-1) negates to itself.
  always_comb begin
    res_hi = acc[2*WIDTH-1:WIDTH];
    res_lo = acc[WIDTH-1:0];
    if (!op_is_div(op_q)) begin
`ifdef MUL_DIV_UNIT_FAST_MUL_EN
      {res_hi, res_lo} = acc;
`else
      {res_hi, res_lo} = neg_q ? -acc : acc;
`endif
    end else if (b_q == '0) begin
      res_hi = a_q;
      res_lo = '1;
    end else begin
      res_lo = neg_q  ? -acc[WIDTH-1:0]         : acc[WIDTH-1:0];
      res_hi = rneg_q ? -acc[2*WIDTH-1:WIDTH]   : acc[2*WIDTH-1:WIDTH];
    end
  end

  // Datapath: capture operands, form magnitudes, iterate, and write HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_MULT;
      a_q    <= '0;
      b_q    <= '0;
      opnd   <= '0;
      acc    <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            op_q <= op_e'(op);
            a_q  <= a;
            b_q  <= b;
          end
        end
        ST_PREP: begin
          opnd   <= mag(b_q, op_is_signed(op_q));
          acc    <= {{WIDTH{1'b0}}, mag(a_q, op_is_signed(op_q))};
          neg_q  <= op_is_signed(op_q) & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          rneg_q <= op_is_signed(op_q) & a_q[WIDTH-1];
          cnt    <= '0;
        end
        ST_CALC: begin
          acc <= step_nx;
          cnt <= cnt + CW'(1);
        end
        ST_FIX: begin
          if (fix_wr) begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
          end
`ifdef MUL_DIV_UNIT_FAST_MUL_EN
          else begin
            acc <= fast_prod;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed vector bench for mul_div_unit (WIDTH=32) with hand-computed HI/LO results.
// Also checks done latency, the busy/start-ignore rule, direct writes and mid-operation reset.
// Inputs are driven on the falling edge, and outputs are sampled 1 time unit after the rising edge.
module tb_mul_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [1:0] o);
`ifdef MUL_DIV_UNIT_FAST_MUL_EN
    return o[1] ? W + 2 : 2;
`else
    return (o == 2'b00) ? W + 2 : W + 2;
`endif
  endfunction

  // Counts edges after the start edge until done is seen; -1 means the bound expired.
  task automatic wait_done(output int lat, output logic bz);
    lat = -1;
    bz  = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        bz  = busy;
        break;
      end
    end
  endtask

  task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int lat, output logic bz);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bz);
  endtask

  initial begin
    int   lat;
    logic bz;
    int   ndone;
    logic [W-1:0] prev_hi;

    vt[0]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vt[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vt[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vt[3]  = '{2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
    vt[4]  = '{2'b10, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
    vt[5]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vt[6]  = '{2'b01, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F};
    vt[7]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vt[8]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vt[9]  = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vt[10] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
    vt[11] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

    // Reset state
    #12;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven operations
    for (int i = 0; i < 12; i++) begin
      do_op(vt[i].op, vt[i].a, vt[i].b, lat, bz);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(exp_lat(vt[i].op)));
      chk($sformatf("v%0d_busy", i), 64'(bz), 64'(0));
      chk($sformatf("v%0d_hi", i), 64'(hi), 64'(vt[i].hi));
      chk($sformatf("v%0d_lo", i), 64'(lo), 64'(vt[i].lo));
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), 64'(done), 64'(0));
    end

    // A second start and a HI write while busy must both be ignored
    prev_hi = hi;
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd7; b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd5; hi_we = 1'b1; wdata = 32'h1234;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    chk("busy_hi_we_ignored", 64'(hi), 64'(prev_hi));
    chk("busy_still", 64'(busy), 64'(1));
    ndone = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("single_done", 64'(ndone), 64'(1));
    chk("ignore_hi", 64'(hi), 64'(1));
    chk("ignore_lo", 64'(lo), 64'(3));

    // A direct HI write in IDLE lands on the next edge
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h1234;
    @(posedge clk); #1;
    hi_we = 1'b0;
    chk("idle_hi_we", 64'(hi), 64'(32'h1234));
    chk("idle_lo_kept", 64'(lo), 64'(3));

    // A direct LO write and start in the same IDLE cycle both take effect
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd4; lo_we = 1'b1; wdata = 32'hABCD;
    @(posedge clk); #1;
    start = 1'b0; lo_we = 1'b0;
    chk("wr_start_lo", 64'(lo), 64'(32'hABCD));
    chk("wr_start_busy", 64'(busy), 64'(1));
    wait_done(lat, bz);
    chk("wr_start_lat", 64'(lat), 64'(W + 2));
    chk("wr_start_res_hi", 64'(hi), 64'(1));
    chk("wr_start_res_lo", 64'(lo), 64'(2));

    // An asynchronous reset in the middle of an operation
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'hFFFF_FFFF; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_hi", 64'(hi), 64'(0));
    chk("midrst_lo", 64'(lo), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    do_op(2'b11, 32'd100, 32'd7, lat, bz);
    chk("post_rst_lat", 64'(lat), 64'(W + 2));
    chk("post_rst_hi", 64'(hi), 64'(2));
    chk("post_rst_lo", 64'(lo), 64'(14));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
